// File: rtl/mips_icache_pkg.sv
// Shared constants for the instruction cache: FSM state encodings and the
// instruction word presented before anything has been fetched.
package mips_icache_pkg;
    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_FILL = 2'd1;
    localparam logic [1:0]  ST_RESP = 2'd2;
    localparam logic [31:0] NOP     = 32'h0000_0000;
endpackage

// File: rtl/icache_tag_array.sv
// Tag store and valid vector for the direct-mapped instruction cache.
// Lookup is combinational; valid bits are cleared by reset or flush.
module icache_tag_array #(
    parameter int LINES = 16,
    parameter int TAG_W = 24,
    localparam int IW   = $clog2(LINES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [IW-1:0]    i_rd_idx,
    input  logic [TAG_W-1:0] i_rd_tag,
    input  logic             i_wr_en,
    input  logic             i_wr_valid,
    input  logic [IW-1:0]    i_wr_idx,
    input  logic [TAG_W-1:0] i_wr_tag,
    output logic             o_hit
);
    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag [LINES];

    // Flush takes priority so a line completing in the same cycle stays invalid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else if (i_wr_en && i_wr_valid) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx] <= i_wr_tag;
        end
    end

    assign o_hit = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag) && !flush;
endmodule

// File: rtl/mips_icache.sv
// Direct-mapped read-only instruction cache. Hits answer one cycle after the
// PC is accepted; misses fill the whole line in word order, then answer.
module mips_icache
    import mips_icache_pkg::*;
#(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_pc,
    output logic [31:0] cpu_instr,
    output logic        cpu_ready,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam int OW    = $clog2(LINE_WORDS);
    localparam int IW    = $clog2(LINES);
    localparam int TAG_W = 30 - OW - IW;
    localparam logic [OW-1:0] LAST_WORD = OW'(LINE_WORDS - 1);

    logic [1:0]    r_state;
    logic [OW-1:0] r_cnt;
    logic [31:0]   r_miss_pc;
    logic          r_flush_pend;
    logic [31:0]   r_instr;
    logic          r_ready;
    logic          r_mem_req;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_data [LINES*LINE_WORDS];

    logic [IW-1:0]    w_idx;
    logic [OW-1:0]    w_off;
    logic [TAG_W-1:0] w_tag;
    logic [IW-1:0]    w_miss_idx;
    logic [OW-1:0]    w_miss_off;
    logic [TAG_W-1:0] w_miss_tag;
    logic             w_hit;
    logic             w_fill_ack;
    logic             w_fill_last;
    logic             w_unused;

    assign w_idx       = cpu_pc[2+OW +: IW];
    assign w_off       = cpu_pc[2 +: OW];
    assign w_tag       = cpu_pc[31 -: TAG_W];
    assign w_miss_idx  = r_miss_pc[2+OW +: IW];
    assign w_miss_off  = r_miss_pc[2 +: OW];
    assign w_miss_tag  = r_miss_pc[31 -: TAG_W];
    assign w_fill_ack  = (r_state == ST_FILL) && mem_ack;
    assign w_fill_last = w_fill_ack && (r_cnt == LAST_WORD);
    assign w_unused    = &{1'b0, cpu_pc[1:0], r_miss_pc[1:0]};

    icache_tag_array #(
        .LINES (LINES),
        .TAG_W (TAG_W)
    ) u_tags (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .i_rd_idx   (w_idx),
        .i_rd_tag   (w_tag),
        .i_wr_en    (w_fill_last),
        .i_wr_valid (!r_flush_pend),
        .i_wr_idx   (w_miss_idx),
        .i_wr_tag   (w_miss_tag),
        .o_hit      (w_hit)
    );

    always_ff @(posedge clk) begin
        if (w_fill_ack) begin
            r_data[{w_miss_idx, r_cnt}] <= mem_rdata;
        end
    end

    // r_flush_pend remembers a flush seen mid-fill so the filled line is not validated.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_miss_pc    <= '0;
            r_flush_pend <= 1'b0;
            r_instr      <= NOP;
            r_ready      <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_flush_pend <= 1'b0;
                    if (cpu_req) begin
                        if (w_hit) begin
                            r_instr <= r_data[{w_idx, w_off}];
                            r_ready <= 1'b1;
                        end else begin
                            r_ready    <= 1'b0;
                            r_miss_pc  <= cpu_pc;
                            r_cnt      <= '0;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= {cpu_pc[31:2+OW], {OW{1'b0}}, 2'b00};
                            r_state    <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (flush) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (mem_ack) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_WORD) begin
                            r_mem_req <= 1'b0;
                            r_state   <= ST_RESP;
                        end else begin
                            r_mem_addr <= r_mem_addr + 32'd4;
                        end
                    end
                end
                ST_RESP: begin
                    r_instr <= r_data[{w_miss_idx, w_miss_off}];
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_instr = r_instr;
    assign cpu_ready = r_ready;
    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
endmodule
